// File: rtl/siso_johnson8.sv
// Serial-in/serial-out delay line clocked down by an 8-phase Johnson counter.
// The DEPTH-stage shift register advances once per full Johnson revolution.
module siso_johnson8 #(
    parameter int DEPTH = 8  // legal range 2..32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic       D_IN,
    output logic       D_OUT,
    output logic [3:0] JOHNSON,
    output logic [7:0] PULSES,
    output logic       SHIFT,
    output logic       VALID
);

    localparam int            CW   = $clog2(DEPTH + 2);
    localparam logic [CW-1:0] LAST = CW'(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH + 1);

    logic [3:0]       johnson_q, johnson_d;
    logic [DEPTH-1:0] sr_q, sr_d;
    logic             dout_q, dout_d;
    logic [7:0]       pulses_q, pulses_d;
    logic             shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;

    logic             legal;
    logic [2:0]       phase;
    logic [2:0]       phase_nxt;
    logic             shift_edge;

    // Map the Johnson code to its phase index; anything else is an illegal code.
    always_comb begin
        legal = 1'b1;
        phase = 3'd0;
        case (johnson_q)
            4'b0000: phase = 3'd0;
            4'b0001: phase = 3'd1;
            4'b0011: phase = 3'd2;
            4'b0111: phase = 3'd3;
            4'b1111: phase = 3'd4;
            4'b1110: phase = 3'd5;
            4'b1100: phase = 3'd6;
            4'b1000: phase = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    assign phase_nxt  = phase + 3'd1;
    assign shift_edge = EN && (johnson_q == 4'b1000);

    always_comb begin
        johnson_d = johnson_q;
        sr_d      = sr_q;
        dout_d    = dout_q;
        pulses_d  = '0;
        shift_d   = 1'b0;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        if (EN) begin
            // Illegal codes collapse to phase 0 silently, without a strobe.
            if (legal) begin
                johnson_d = {johnson_q[2:0], ~johnson_q[3]};
                pulses_d  = 8'b1 << phase_nxt;
            end else begin
                johnson_d = '0;
            end
            if (shift_edge) begin
                sr_d    = {sr_q[DEPTH-2:0], D_IN};
                dout_d  = sr_q[DEPTH-1];
                shift_d = 1'b1;
                if (cnt_q != FULL)
                    cnt_d = cnt_q + 1'b1;
                // DEPTH+1-th shift is the first to put sampled data on D_OUT.
                valid_d = valid_q | (cnt_q >= LAST);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            johnson_q <= '0;
            sr_q      <= '0;
            dout_q    <= 1'b0;
            pulses_q  <= '0;
            shift_q   <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            johnson_q <= johnson_d;
            sr_q      <= sr_d;
            dout_q    <= dout_d;
            pulses_q  <= pulses_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
        end
    end

    assign D_OUT   = dout_q;
    assign JOHNSON = johnson_q;
    assign PULSES  = pulses_q;
    assign SHIFT   = shift_q;
    assign VALID   = valid_q;

endmodule

// File: tb/tb_siso_johnson8.sv
// Scenario bench for siso_johnson8: Johnson/PULSES walk, data latency via a
// bit scoreboard, EN gating, illegal-code recovery and mid-stream reset.
module tb_siso_johnson8;

    localparam int DEPTH = 8;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic       D_IN;
    logic       D_OUT;
    logic [3:0] JOHNSON;
    logic [7:0] PULSES;
    logic       SHIFT;
    logic       VALID;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    siso_johnson8 #(.DEPTH(DEPTH)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .EN     (EN),
        .D_IN   (D_IN),
        .D_OUT  (D_OUT),
        .JOHNSON(JOHNSON),
        .PULSES (PULSES),
        .SHIFT  (SHIFT),
        .VALID  (VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        EN    = 1'b1;
        D_IN  = 1'b1;
        tick();
        tick();
        checks++; if (JOHNSON !== 4'b0000) begin errors++; $display("FAIL reset_johnson got %b want 0000", JOHNSON); end
        checks++; if (PULSES !== 8'h00) begin errors++; $display("FAIL reset_pulses got %h want 00", PULSES); end
        checks++; if (D_OUT !== 1'b0) begin errors++; $display("FAIL reset_dout got %b want 0", D_OUT); end
        checks++; if (SHIFT !== 1'b0) begin errors++; $display("FAIL reset_shift got %b want 0", SHIFT); end
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", VALID); end
    endtask

    task automatic test_sequence();
        logic [3:0] jt [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        logic [7:0] pt [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        RESET = 1'b1;
        EN    = 1'b1;
        D_IN  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (JOHNSON !== jt[i%8]) begin errors++; $display("FAIL seq_johnson step %0d got %b want %b", i, JOHNSON, jt[i%8]); end
            checks++; if (PULSES !== pt[i%8]) begin errors++; $display("FAIL seq_pulses step %0d got %h want %h", i, PULSES, pt[i%8]); end
            checks++; if (SHIFT !== ((i % 8) == 7)) begin errors++; $display("FAIL seq_shift step %0d got %b want %b", i, SHIFT, ((i % 8) == 7)); end
        end
    endtask

    task automatic test_data_latency();
        bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int nshift = 0;
        bit exp;
        apply_reset();
        exp_q.delete();
        for (int p = 0; p < 16; p++) begin
            D_IN = (p < 8) ? pat[p] : 1'b0;
            for (int t = 0; t < 8; t++) begin
                tick();
                checks++; if (SHIFT !== (t == 7)) begin errors++; $display("FAIL data_shift_timing period %0d cyc %0d got %b want %b", p, t, SHIFT, (t == 7)); end
                if (SHIFT === 1'b1) begin
                    nshift++;
                    exp_q.push_back(D_IN);
                    if (nshift <= DEPTH) begin
                        checks++; if (D_OUT !== 1'b0 || VALID !== 1'b0) begin errors++; $display("FAIL data_fill shift %0d got dout=%b valid=%b want dout=0 valid=0", nshift, D_OUT, VALID); end
                    end else begin
                        exp = exp_q.pop_front();
                        checks++; if (D_OUT !== exp) begin errors++; $display("FAIL data_dout shift %0d got %b want %b", nshift, D_OUT, exp); end
                        checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL data_valid shift %0d got %b want 1", nshift, VALID); end
                    end
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_en_gating();
        int n;
        apply_reset();
        D_IN = 1'b1;
        repeat (8) tick();
        checks++; if (SHIFT !== 1'b1) begin errors++; $display("FAIL gate_first_shift got %b want 1", SHIFT); end
        repeat (3) tick();
        checks++; if (JOHNSON !== 4'b0111) begin errors++; $display("FAIL gate_pre_johnson got %b want 0111", JOHNSON); end
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (JOHNSON !== 4'b0111 || PULSES !== 8'h00 || SHIFT !== 1'b0 || D_OUT !== 1'b0 || VALID !== 1'b0) begin
                errors++;
                $display("FAIL gate_hold cyc %0d got j=%b p=%h s=%b d=%b v=%b want j=0111 p=00 s=0 d=0 v=0", i, JOHNSON, PULSES, SHIFT, D_OUT, VALID);
            end
        end
        EN = 1'b1;
        tick();
        checks++; if (JOHNSON !== 4'b1111) begin errors++; $display("FAIL gate_resume_johnson got %b want 1111", JOHNSON); end
        checks++; if (PULSES !== 8'h10) begin errors++; $display("FAIL gate_resume_pulses got %h want 10", PULSES); end
        n = 4;
        while (SHIFT !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL gate_period got %0d enabled cycles want 8", n); end
    endtask

    task automatic test_illegal();
        EN = 1'b1;
        force dut.johnson_q = 4'b0101;
        #1;
        release dut.johnson_q;
        checks++; if (JOHNSON !== 4'b0101) begin errors++; $display("FAIL illegal_forced got %b want 0101", JOHNSON); end
        tick();
        checks++; if (JOHNSON !== 4'b0000) begin errors++; $display("FAIL illegal_recover got %b want 0000", JOHNSON); end
        checks++; if (SHIFT !== 1'b0) begin errors++; $display("FAIL illegal_shift got %b want 0", SHIFT); end
        checks++; if (PULSES !== 8'h00) begin errors++; $display("FAIL illegal_pulses got %h want 00", PULSES); end
        checks++; if (D_OUT !== 1'b0) begin errors++; $display("FAIL illegal_dout got %b want 0", D_OUT); end
        tick();
        checks++; if (JOHNSON !== 4'b0001) begin errors++; $display("FAIL illegal_next_johnson got %b want 0001", JOHNSON); end
        checks++; if (PULSES !== 8'h02) begin errors++; $display("FAIL illegal_next_pulses got %h want 02", PULSES); end
    endtask

    task automatic test_reset_midstream();
        int n;
        apply_reset();
        D_IN = 1'b1;
        repeat (10 * 8) tick();
        checks++; if (VALID !== 1'b1 || D_OUT !== 1'b1) begin errors++; $display("FAIL mid_prefill got valid=%b dout=%b want 1 1", VALID, D_OUT); end
        repeat (6) tick();
        checks++; if (JOHNSON !== 4'b1100) begin errors++; $display("FAIL mid_phase got %b want 1100", JOHNSON); end
        RESET = 1'b0;
        tick();
        checks++;
        if (JOHNSON !== 4'b0000 || PULSES !== 8'h00 || D_OUT !== 1'b0 || SHIFT !== 1'b0 || VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got j=%b p=%h d=%b s=%b v=%b want all zero", JOHNSON, PULSES, D_OUT, SHIFT, VALID);
        end
        RESET = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (SHIFT !== 1'b1 && n < 20);
        checks++; if (n != 8) begin errors++; $display("FAIL mid_first_shift got %0d cycles want 8", n); end
        for (int s = 2; s <= DEPTH + 1; s++) begin
            repeat (8) tick();
            checks++; if (SHIFT !== 1'b1) begin errors++; $display("FAIL mid_shift_%0d got %b want 1", s, SHIFT); end
            if (s <= DEPTH) begin
                checks++; if (VALID !== 1'b0 || D_OUT !== 1'b0) begin errors++; $display("FAIL mid_fill shift %0d got valid=%b dout=%b want 0 0", s, VALID, D_OUT); end
            end else begin
                checks++; if (VALID !== 1'b1 || D_OUT !== 1'b1) begin errors++; $display("FAIL mid_valid shift %0d got valid=%b dout=%b want 1 1", s, VALID, D_OUT); end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0;
        EN    = 1'b1;
        D_IN  = 1'b0;
        test_reset();
        test_sequence();
        test_data_latency();
        test_en_gating();
        test_illegal();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
